muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit beside the ALU in the execute stage. Takes the
//  same rs/rt operands the ALU receives from decode/forwarding and owns the
//  architectural HI/LO registers. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//  Drives md_busy so hazard logic stalls any MFHI/MFLO or new mul/div op issued
//  while an operation is in flight.
// PARAMETERS
//  WIDTH      32  operand width; HI/LO are WIDTH each; product is 2*WIDTH
//  MUL_STAGES 2   multiply latency in cycles (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active low
//  md_start   in   1      op valid from execute; sampled only in IDLE
//  md_opcode  in   3      0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO; 7 = NOP
//  md_op_x    in   WIDTH  rs: multiplicand / dividend / MTxx source
//  md_op_y    in   WIDTH  rt: multiplier / divisor
//  md_flush   in   1      kill the in-flight op (branch/exception squash)
//  md_busy    out  1      high while state != IDLE
//  md_done    out  1      one-cycle pulse; HI/LO hold the new result that cycle
//  md_hi      out  WIDTH  HI register
//  md_lo      out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, md_hi=md_lo=0, md_busy=0, md_done=0,
//    all internal counters and partial results cleared. Takes effect mid-op too.
//  - States: IDLE, MUL, DIV, FIX. busy = (state != IDLE), decoded from the register.
//  - Accept edge E0: IDLE & md_start & ~md_flush & opcode in 1..6.
//    md_start outside IDLE is ignored, never queued.
//  - MTHI/MTLO: write md_op_x into HI/LO at E0. No busy, no done.
//  - MULT/MULTU: IDLE->MUL at E0. Operands latched at E0; full 2*WIDTH product.
//    Signed for MULT, unsigned for MULTU. At edge E0+MUL_STAGES: HI=upper half,
//    LO=lower half, state->IDLE, done=1 for exactly that following cycle.
//  - DIV/DIVU: IDLE->DIV at E0. Operands latched as magnitudes (DIV: abs value;
//    abs(0x80000000) = 2^31 unsigned). Sign flags latched too. Restoring divide,
//    one quotient bit per cycle, WIDTH cycles, 5-bit count down to 0. Then FIX,
//    one cycle: quotient negated if xs^ys, remainder negated if xs (DIV only).
//    HI/LO update, done pulse and state->IDLE at edge E0+WIDTH+1.
//    md_busy is high for WIDTH+1 cycles.
//  - Divide by zero (md_op_y==0, DIV or DIVU): no iteration. FIX at E0.
//    At E0+1: LO=all ones, HI=md_op_x as given, done pulse.
//  - Overflow case DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0. No trap; the
//    unit never signals overflow.
//  - HI/LO change only at MTHI/MTLO accept or on a done edge. They are stable otherwise.
//  - md_flush: in MUL/DIV/FIX, go to IDLE next edge. HI/LO unchanged, no done pulse.
//    In IDLE, flush blocks acceptance of a simultaneous md_start, including MTxx.
//  - Completion edge and new start: start is not sampled on the done edge, because
//    the state is not IDLE then. The next op is accepted no earlier than the cycle
//    where done=1.
// TESTING
//  1 MULT 0xFFFFFFFF x 0x00000002 -> after 2 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE,
//    done 1 cycle; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE
//  2 DIV -7 (0xFFFFFFF9) / 2 -> busy exactly 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF;
//    DIVU 100/7 -> LO=14, HI=2
//  3 DIVU 100 / 0 -> busy 1 cycle, LO=0xFFFFFFFF, HI=0x00000064;
//    DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0
//  4 MTHI 0xDEADBEEF then MTLO 0x12345678 on back-to-back cycles ->
//    HI/LO updated each next edge, busy stays 0
//  5 DIV started, md_flush at cycle 10 -> busy=0 next cycle, HI/LO keep prior values,
//    no done; md_start pulsed during busy -> ignored
//  6 rst_n low mid-DIV (cycle 5) -> busy, done, HI and LO 0 immediately without a
//    clock edge; new MULT after release completes normally

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers.
// Multiply completes after MUL_STAGES cycles; divide is restoring, one bit per cycle plus a sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             md_start,
    input  logic [2:0]       md_opcode,
    input  logic [WIDTH-1:0] md_op_x,
    input  logic [WIDTH-1:0] md_op_y,
    input  logic             md_flush,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, hi_q, hi_d, lo_q, lo_d;
    logic             sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d;

    logic             accept, is_mul, is_div, div_s, y_zero, xs, ys, last, ge;
    logic [WIDTH-1:0] xm, ym;
    logic [WIDTH:0]   r_sh;
    logic [2*WIDTH-1:0] ma, mb, prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        accept = state_q == IDLE && md_start && !md_flush && md_opcode inside {[3'd1:3'd6]};
        is_mul = md_opcode == 3'd1 || md_opcode == 3'd2;
        is_div = md_opcode == 3'd3 || md_opcode == 3'd4;
        y_zero = md_op_y == '0;
        last   = cnt_q == '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept ? IDLE : is_mul ? MUL : is_div ? (y_zero ? FIX : DIV) : IDLE;
            MUL:     state_d = last ? IDLE : MUL;
            DIV:     state_d = last ? FIX : DIV;
            default: state_d = IDLE;
        endcase
        if (md_flush) state_d = IDLE;
    end

    always_comb begin
        div_s = md_opcode == 3'd3;
        xs    = div_s & md_op_x[WIDTH-1];
        ys    = div_s & md_op_y[WIDTH-1];
        xm    = xs ? -md_op_x : md_op_x;
        ym    = ys ? -md_op_y : md_op_y;
        // Only the low 2*WIDTH product bits matter, so sign-extend and multiply modulo 2^(2*WIDTH).
        ma    = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        mb    = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod  = ma * mb;
        r_sh  = {r_q, a_q[WIDTH-1]};
        ge    = r_sh >= {1'b0, b_q};
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        r_d    = r_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        sgn_d  = sgn_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                hi_d   = md_opcode == 3'd5 ? md_op_x : hi_q;
                lo_d   = md_opcode == 3'd6 ? md_op_x : lo_q;
                sgn_d  = md_opcode == 3'd1;
                cnt_d  = is_mul ? CW'(MUL_STAGES - 1) : CW'(WIDTH - 1);
                // Divide by zero preloads quotient=all ones and remainder=dividend so FIX passes them through.
                a_d    = is_mul ? md_op_x : y_zero ? '1 : xm;
                b_d    = is_mul ? md_op_y : ym;
                r_d    = y_zero ? md_op_x : '0;
                qneg_d = !y_zero & (xs ^ ys);
                rneg_d = !y_zero & xs;
            end
            MUL: begin
                cnt_d  = cnt_q - CW'(1);
                hi_d   = last && !md_flush ? prod[2*WIDTH-1:WIDTH] : hi_q;
                lo_d   = last && !md_flush ? prod[WIDTH-1:0] : lo_q;
                done_d = last && !md_flush;
            end
            DIV: begin
                cnt_d = cnt_q - CW'(1);
                a_d   = {a_q[WIDTH-2:0], ge};
                r_d   = ge ? r_sh[WIDTH-1:0] - b_q : r_sh[WIDTH-1:0];
            end
            default: begin
                hi_d   = md_flush ? hi_q : rneg_q ? -r_q : r_q;
                lo_d   = md_flush ? lo_q : qneg_q ? -a_q : a_q;
                done_d = !md_flush;
            end
        endcase
    end

    always_comb begin
        md_busy = state_q != IDLE;
        md_done = done_q;
        md_hi   = hi_q;
        md_lo   = lo_q;
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven directed vectors plus hand sequences for flush, ignored start and async reset.
module tb_muldiv_unit;
    logic        clk = 1'b0, rst_n = 1'b0, md_start = 1'b0, md_flush = 1'b0;
    logic [2:0]  md_opcode = 3'd0;
    logic [31:0] md_op_x = '0, md_op_y = '0;
    logic        md_busy, md_done;
    logic [31:0] md_hi, md_lo;
    int          tests = 0, fails = 0;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_opcode(md_opcode),
        .md_op_x(md_op_x), .md_op_y(md_op_y), .md_flush(md_flush),
        .md_busy(md_busy), .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x, y, hi, lo;
        int          cyc;
        logic        done;
    } vec_t;

    vec_t v[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        md_opcode = op;
        md_op_x   = x;
        md_op_y   = y;
        md_start  = 1'b1;
        @(negedge clk);
        md_start  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (md_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, seen;
        v[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b1};
        v[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 2, 1'b1};
        v[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b1};
        v[3]  = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1};
        v[4]  = '{3'd4, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1, 1'b1};
        v[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b1};
        v[6]  = '{3'd5, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h80000000, 0, 1'b0};
        v[7]  = '{3'd6, 32'h12345678, 32'h0, 32'hDEADBEEF, 32'h12345678, 0, 1'b0};
        v[8]  = '{3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 2, 1'b1};
        v[9]  = '{3'd3, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b1};
        v[10] = '{3'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33, 1'b1};
        v[11] = '{3'd3, 32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF, 1, 1'b1};
        v[12] = '{3'd3, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, 1'b1};
        v[13] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2, 1'b1};
        v[14] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2, 1'b1};
        v[15] = '{3'd4, 32'hFFFFFFFF, 32'h1, 32'h00000000, 32'hFFFFFFFF, 33, 1'b1};
        v[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33, 1'b1};

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(md_busy), 32'd0);
        chk("reset done", 32'(md_done), 32'd0);
        chk("reset hi", md_hi, 32'd0);
        chk("reset lo", md_lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            issue(v[i].op, v[i].x, v[i].y);
            wait_idle(n);
            chk($sformatf("v%0d busy cycles", i), 32'(n), 32'(v[i].cyc));
            chk($sformatf("v%0d done", i), 32'(md_done), 32'(v[i].done));
            chk($sformatf("v%0d hi", i), md_hi, v[i].hi);
            chk($sformatf("v%0d lo", i), md_lo, v[i].lo);
            @(negedge clk);
            chk($sformatf("v%0d done pulse end", i), 32'(md_done), 32'd0);
        end

        // Back-to-back MTHI then MTLO, followed by NOP opcodes 0 and 7.
        md_start = 1'b1; md_opcode = 3'd5; md_op_x = 32'hDEADBEEF;
        @(negedge clk);
        chk("mthi hi", md_hi, 32'hDEADBEEF);
        chk("mthi busy", 32'(md_busy), 32'd0);
        md_opcode = 3'd6; md_op_x = 32'h12345678;
        @(negedge clk);
        chk("mtlo lo", md_lo, 32'h12345678);
        chk("mtlo hi", md_hi, 32'hDEADBEEF);
        chk("mtlo busy", 32'(md_busy), 32'd0);
        md_opcode = 3'd0; md_op_x = 32'h0;
        @(negedge clk);
        md_opcode = 3'd7;
        @(negedge clk);
        md_start = 1'b0;
        chk("nop busy", 32'(md_busy), 32'd0);
        chk("nop hi", md_hi, 32'hDEADBEEF);
        chk("nop lo", md_lo, 32'h12345678);

        // Flush in IDLE blocks even an MTHI.
        md_flush = 1'b1;
        issue(3'd5, 32'h0BADF00D, 32'h0);
        md_flush = 1'b0;
        chk("idle flush hi", md_hi, 32'hDEADBEEF);

        // Flush mid-divide with a stray start pulse while busy.
        issue(3'd4, 32'd100, 32'd7);
        md_opcode = 3'd1; md_op_x = 32'd3; md_op_y = 32'd4; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        repeat (7) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        chk("flush busy", 32'(md_busy), 32'd0);
        chk("flush done", 32'(md_done), 32'd0);
        chk("flush hi", md_hi, 32'hDEADBEEF);
        chk("flush lo", md_lo, 32'h12345678);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(md_done) + int'(md_busy);
        end
        chk("flush no late activity", 32'(seen), 32'd0);

        // Start pulsed during a divide is dropped, not queued.
        issue(3'd4, 32'd100, 32'd7);
        md_opcode = 3'd1; md_op_x = 32'd3; md_op_y = 32'd4; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        wait_idle(n);
        chk("ignored start cycles", 32'(n + 1), 32'd33);
        chk("ignored start done", 32'(md_done), 32'd1);
        chk("ignored start hi", md_hi, 32'd2);
        chk("ignored start lo", md_lo, 32'd14);
        @(negedge clk);
        chk("ignored start not queued", 32'(md_busy), 32'd0);

        // Async reset mid-divide, then a normal multiply.
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst busy", 32'(md_busy), 32'd0);
        chk("async rst done", 32'(md_done), 32'd0);
        chk("async rst hi", md_hi, 32'd0);
        chk("async rst lo", md_lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'd1, 32'd3, 32'd4);
        wait_idle(n);
        chk("post rst mult cycles", 32'(n), 32'd2);
        chk("post rst mult done", 32'(md_done), 32'd1);
        chk("post rst mult hi", md_hi, 32'd0);
        chk("post rst mult lo", md_lo, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
